// File: rtl/reservation_station_if.sv
// Dispatcher / CDB / RoB / ALU bundle seen by the reservation station.
// The master side drives dispatch, broadcast and flush. The slave side (the RS)
// drives fullness and the issued instruction.
interface reservation_station_if #(
   parameter int ADDR_WIDTH   = 32,
   parameter int RoB_WIDTH    = 8,
   parameter int EX_RoB_WIDTH = 9
);
   // dispatcher -> RS
   logic                    DPRS_en;
   logic [ADDR_WIDTH-1:0]   DPRS_pc;
   logic [6:0]              DPRS_opcode;
   logic [31:0]             DPRS_imm;
   logic [31:0]             DPRS_Vj;
   logic [31:0]             DPRS_Vk;
   logic [EX_RoB_WIDTH-1:0] DPRS_Qj;
   logic [EX_RoB_WIDTH-1:0] DPRS_Qk;
   logic [RoB_WIDTH-1:0]    DPRS_RoB_index;
   logic                    RSDP_full;

   // common data buses
   logic                    CDBRS_RS_en;
   logic [RoB_WIDTH-1:0]    CDBRS_RS_RoB_index;
   logic [31:0]             CDBRS_RS_value;
   logic                    CDBRS_LSB_en;
   logic [RoB_WIDTH-1:0]    CDBRS_LSB_RoB_index;
   logic [31:0]             CDBRS_LSB_value;

   // reorder buffer
   logic                    RoBRS_pre_judge;

   // RS -> ALU
   logic                    RSALU_en;
   logic [6:0]              RSALU_opcode;
   logic [ADDR_WIDTH-1:0]   RSALU_pc;
   logic [31:0]             RSALU_imm;
   logic [31:0]             RSALU_Vj;
   logic [31:0]             RSALU_Vk;
   logic [RoB_WIDTH-1:0]    RSALU_RoB_index;

   modport master (
      output DPRS_en, DPRS_pc, DPRS_opcode, DPRS_imm, DPRS_Vj, DPRS_Vk,
             DPRS_Qj, DPRS_Qk, DPRS_RoB_index,
             CDBRS_RS_en, CDBRS_RS_RoB_index, CDBRS_RS_value,
             CDBRS_LSB_en, CDBRS_LSB_RoB_index, CDBRS_LSB_value,
             RoBRS_pre_judge,
      input  RSDP_full,
             RSALU_en, RSALU_opcode, RSALU_pc, RSALU_imm, RSALU_Vj, RSALU_Vk,
             RSALU_RoB_index
   );

   modport slave (
      input  DPRS_en, DPRS_pc, DPRS_opcode, DPRS_imm, DPRS_Vj, DPRS_Vk,
             DPRS_Qj, DPRS_Qk, DPRS_RoB_index,
             CDBRS_RS_en, CDBRS_RS_RoB_index, CDBRS_RS_value,
             CDBRS_LSB_en, CDBRS_LSB_RoB_index, CDBRS_LSB_value,
             RoBRS_pre_judge,
      output RSDP_full,
             RSALU_en, RSALU_opcode, RSALU_pc, RSALU_imm, RSALU_Vj, RSALU_Vk,
             RSALU_RoB_index
   );
endinterface

// File: rtl/reservation_station.sv
// Reservation station for ALU/branch/jump instructions.
// Buffers dispatched instructions and wakes their operands by snooping both CDBs.
// Issues the lowest-index operand-ready entry each cycle.
// Readiness is taken from registered state only, so an entry written or woken
// at one edge is issued no earlier than the next edge.
module reservation_station #(
   parameter int ADDR_WIDTH   = 32,
   parameter int RS_SIZE      = 16,
   parameter int RS_WIDTH     = 4,
   parameter int RoB_WIDTH    = 8,
   parameter int EX_RoB_WIDTH = 9,
   parameter logic [EX_RoB_WIDTH-1:0] NON_DEP = {1'b1, {(EX_RoB_WIDTH-1){1'b0}}}
) (
   input  logic                 Sys_clk,
   input  logic                 Sys_rst,
   input  logic                 Sys_rdy,
   reservation_station_if.slave bus
);

   // entry storage
   logic [RS_SIZE-1:0]      busy_reg;
   logic [RS_SIZE-1:0]      busy_next;
   logic [6:0]              opcode_reg [RS_SIZE];
   logic [ADDR_WIDTH-1:0]   pc_reg     [RS_SIZE];
   logic [31:0]             imm_reg    [RS_SIZE];
   logic [31:0]             vj_reg     [RS_SIZE];
   logic [31:0]             vk_reg     [RS_SIZE];
   logic [EX_RoB_WIDTH-1:0] qj_reg     [RS_SIZE];
   logic [EX_RoB_WIDTH-1:0] qk_reg     [RS_SIZE];
   logic [RoB_WIDTH-1:0]    rob_reg    [RS_SIZE];

   // issue output registers
   logic                    alu_en_reg;
   logic [6:0]              alu_opcode_reg;
   logic [ADDR_WIDTH-1:0]   alu_pc_reg;
   logic [31:0]             alu_imm_reg;
   logic [31:0]             alu_vj_reg;
   logic [31:0]             alu_vk_reg;
   logic [RoB_WIDTH-1:0]    alu_rob_reg;

   // per-entry wakeup / readiness
   logic [RS_SIZE-1:0]      qj_rs_hit;
   logic [RS_SIZE-1:0]      qj_lsb_hit;
   logic [RS_SIZE-1:0]      qk_rs_hit;
   logic [RS_SIZE-1:0]      qk_lsb_hit;
   logic [RS_SIZE-1:0]      ready_vec;

   // selection
   logic                    issue_found;
   logic [RS_WIDTH-1:0]     issue_idx;
   logic                    free_found;
   logic [RS_WIDTH-1:0]     free_idx;
   logic [RS_WIDTH:0]       occ_count;
   logic                    disp_we;

   // dispatch operand forwarding
   logic [EX_RoB_WIDTH-1:0] rs_tag;
   logic [EX_RoB_WIDTH-1:0] lsb_tag;
   logic [31:0]             disp_vj;
   logic [31:0]             disp_vk;
   logic [EX_RoB_WIDTH-1:0] disp_qj;
   logic [EX_RoB_WIDTH-1:0] disp_qk;

   // A bus tag is the RoB index with the MSB clear, so NON_DEP can never match.
   assign rs_tag  = {1'b0, bus.CDBRS_RS_RoB_index};
   assign lsb_tag = {1'b0, bus.CDBRS_LSB_RoB_index};

   generate
      for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
         assign qj_rs_hit[gi]  = busy_reg[gi] && bus.CDBRS_RS_en  && (qj_reg[gi] == rs_tag);
         assign qj_lsb_hit[gi] = busy_reg[gi] && bus.CDBRS_LSB_en && (qj_reg[gi] == lsb_tag);
         assign qk_rs_hit[gi]  = busy_reg[gi] && bus.CDBRS_RS_en  && (qk_reg[gi] == rs_tag);
         assign qk_lsb_hit[gi] = busy_reg[gi] && bus.CDBRS_LSB_en && (qk_reg[gi] == lsb_tag);
         assign ready_vec[gi]  = busy_reg[gi] && (qj_reg[gi] == NON_DEP) && (qk_reg[gi] == NON_DEP);
      end
   endgenerate

   // Lowest-index ready entry to issue and lowest-index free slot for dispatch.
   always_comb begin
      issue_found = 1'b0;
      issue_idx   = '0;
      free_found  = 1'b0;
      free_idx    = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (ready_vec[i]) begin
            issue_found = 1'b1;
            issue_idx   = RS_WIDTH'(i);
         end
         if (!busy_reg[i]) begin
            free_found = 1'b1;
            free_idx   = RS_WIDTH'(i);
         end
      end
   end

   // Occupancy from registered busy bits.
   always_comb begin
      occ_count = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         occ_count = occ_count + {{RS_WIDTH{1'b0}}, busy_reg[i]};
      end
   end

   // One slot of slack absorbs the dispatch already in flight after the full check.
   assign bus.RSDP_full = (occ_count >= (RS_WIDTH+1)'(RS_SIZE - 1));

   // A dispatch with no free slot is dropped.
   assign disp_we = bus.DPRS_en && free_found;

   // Forward same-cycle CDB results into the incoming operands; the RS bus wins a tie.
   always_comb begin
      disp_vj = bus.DPRS_Vj;
      disp_qj = bus.DPRS_Qj;
      disp_vk = bus.DPRS_Vk;
      disp_qk = bus.DPRS_Qk;
      if (bus.CDBRS_RS_en && (bus.DPRS_Qj == rs_tag)) begin
         disp_vj = bus.CDBRS_RS_value;
         disp_qj = NON_DEP;
      end else if (bus.CDBRS_LSB_en && (bus.DPRS_Qj == lsb_tag)) begin
         disp_vj = bus.CDBRS_LSB_value;
         disp_qj = NON_DEP;
      end
      if (bus.CDBRS_RS_en && (bus.DPRS_Qk == rs_tag)) begin
         disp_vk = bus.CDBRS_RS_value;
         disp_qk = NON_DEP;
      end else if (bus.CDBRS_LSB_en && (bus.DPRS_Qk == lsb_tag)) begin
         disp_vk = bus.CDBRS_LSB_value;
         disp_qk = NON_DEP;
      end
   end

   // Next busy vector: issue frees a ready entry and dispatch claims a free one.
   // These are never the same slot.
   always_comb begin
      busy_next = busy_reg;
      if (issue_found) busy_next[issue_idx] = 1'b0;
      if (disp_we)     busy_next[free_idx]  = 1'b1;
   end

   // Busy bits and issue registers; a flush overrides everything, even a stall.
   always_ff @(posedge Sys_clk or posedge Sys_rst) begin
      if (Sys_rst) begin
         busy_reg       <= '0;
         alu_en_reg     <= 1'b0;
         alu_opcode_reg <= '0;
         alu_pc_reg     <= '0;
         alu_imm_reg    <= '0;
         alu_vj_reg     <= '0;
         alu_vk_reg     <= '0;
         alu_rob_reg    <= '0;
      end else if (!bus.RoBRS_pre_judge) begin
         busy_reg   <= '0;
         alu_en_reg <= 1'b0;
      end else if (Sys_rdy) begin
         busy_reg   <= busy_next;
         alu_en_reg <= issue_found;
         if (issue_found) begin
            alu_opcode_reg <= opcode_reg[issue_idx];
            alu_pc_reg     <= pc_reg[issue_idx];
            alu_imm_reg    <= imm_reg[issue_idx];
            alu_vj_reg     <= vj_reg[issue_idx];
            alu_vk_reg     <= vk_reg[issue_idx];
            alu_rob_reg    <= rob_reg[issue_idx];
         end
      end
   end

   // Entry payload: write on dispatch, otherwise capture matching CDB values.
   // The payload needs no reset because busy gates every use of it.
   always_ff @(posedge Sys_clk) begin
      if (Sys_rdy) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (disp_we && (free_idx == RS_WIDTH'(i))) begin
               opcode_reg[i] <= bus.DPRS_opcode;
               pc_reg[i]     <= bus.DPRS_pc;
               imm_reg[i]    <= bus.DPRS_imm;
               vj_reg[i]     <= disp_vj;
               vk_reg[i]     <= disp_vk;
               qj_reg[i]     <= disp_qj;
               qk_reg[i]     <= disp_qk;
               rob_reg[i]    <= bus.DPRS_RoB_index;
            end else begin
               if (qj_rs_hit[i]) begin
                  vj_reg[i] <= bus.CDBRS_RS_value;
                  qj_reg[i] <= NON_DEP;
               end else if (qj_lsb_hit[i]) begin
                  vj_reg[i] <= bus.CDBRS_LSB_value;
                  qj_reg[i] <= NON_DEP;
               end
               if (qk_rs_hit[i]) begin
                  vk_reg[i] <= bus.CDBRS_RS_value;
                  qk_reg[i] <= NON_DEP;
               end else if (qk_lsb_hit[i]) begin
                  vk_reg[i] <= bus.CDBRS_LSB_value;
                  qk_reg[i] <= NON_DEP;
               end
            end
         end
      end
   end

   assign bus.RSALU_en        = alu_en_reg;
   assign bus.RSALU_opcode    = alu_opcode_reg;
   assign bus.RSALU_pc        = alu_pc_reg;
   assign bus.RSALU_imm       = alu_imm_reg;
   assign bus.RSALU_Vj        = alu_vj_reg;
   assign bus.RSALU_Vk        = alu_vk_reg;
   assign bus.RSALU_RoB_index = alu_rob_reg;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: issue latency, CDB wakeup and forwarding,
// stall, full threshold, in-order drain, flush and asynchronous reset.
module tb_reservation_station;
   localparam logic [8:0] ND = 9'b100000000;

   logic Sys_clk = 1'b0;
   logic Sys_rst;
   logic Sys_rdy;
   int   errors = 0;
   int   checks = 0;

   reservation_station_if #(.ADDR_WIDTH(32), .RoB_WIDTH(8), .EX_RoB_WIDTH(9)) rs_bus ();

   reservation_station dut (
      .Sys_clk (Sys_clk),
      .Sys_rst (Sys_rst),
      .Sys_rdy (Sys_rdy),
      .bus     (rs_bus)
   );

   always #5 Sys_clk = ~Sys_clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Sys_clk);
      #1;
   endtask

   task automatic idle_inputs();
      rs_bus.DPRS_en             = 1'b0;
      rs_bus.DPRS_pc             = '0;
      rs_bus.DPRS_opcode         = '0;
      rs_bus.DPRS_imm            = '0;
      rs_bus.DPRS_Vj             = '0;
      rs_bus.DPRS_Vk             = '0;
      rs_bus.DPRS_Qj             = ND;
      rs_bus.DPRS_Qk             = ND;
      rs_bus.DPRS_RoB_index      = '0;
      rs_bus.CDBRS_RS_en         = 1'b0;
      rs_bus.CDBRS_RS_RoB_index  = '0;
      rs_bus.CDBRS_RS_value      = '0;
      rs_bus.CDBRS_LSB_en        = 1'b0;
      rs_bus.CDBRS_LSB_RoB_index = '0;
      rs_bus.CDBRS_LSB_value     = '0;
      rs_bus.RoBRS_pre_judge     = 1'b1;
   endtask

   // Present one instruction for a single edge.
   task automatic dispatch(input logic [6:0] op, input logic [31:0] pc, input logic [31:0] imm,
                           input logic [31:0] vj, input logic [31:0] vk,
                           input logic [8:0] qj, input logic [8:0] qk, input logic [7:0] rob);
      rs_bus.DPRS_en        = 1'b1;
      rs_bus.DPRS_opcode    = op;
      rs_bus.DPRS_pc        = pc;
      rs_bus.DPRS_imm       = imm;
      rs_bus.DPRS_Vj        = vj;
      rs_bus.DPRS_Vk        = vk;
      rs_bus.DPRS_Qj        = qj;
      rs_bus.DPRS_Qk        = qk;
      rs_bus.DPRS_RoB_index = rob;
      tick();
      rs_bus.DPRS_en = 1'b0;
      $display("dispatch op=%0d rob=%0d qj=%h qk=%h", op, rob, qj, qk);
   endtask

   // The stimulus must never dispatch into a full station.
   always @(negedge Sys_clk) begin
      if (!Sys_rst && rs_bus.DPRS_en) check_val("no_overflow", {31'd0, rs_bus.RSDP_full}, 32'd0);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      Sys_rst = 1'b1;
      Sys_rdy = 1'b1;
      idle_inputs();
      #3;
      check_val("rst_en",   {31'd0, rs_bus.RSALU_en},  32'd0);
      check_val("rst_full", {31'd0, rs_bus.RSDP_full}, 32'd0);
      check_val("rst_op",   {25'd0, rs_bus.RSALU_opcode}, 32'd0);
      check_val("rst_vj",   rs_bus.RSALU_Vj, 32'd0);
      tick();
      Sys_rst = 1'b0;
      tick();
      check_val("rst_noissue", {31'd0, rs_bus.RSALU_en}, 32'd0);

      // addi with both operands ready: issue one edge after dispatch
      dispatch(7'd19, 32'h100, 32'd7, 32'd5, 32'd0, ND, ND, 8'd3);
      check_val("addi_lat0", {31'd0, rs_bus.RSALU_en}, 32'd0);
      tick();
      check_val("addi_en",  {31'd0, rs_bus.RSALU_en}, 32'd1);
      check_val("addi_op",  {25'd0, rs_bus.RSALU_opcode}, 32'd19);
      check_val("addi_pc",  rs_bus.RSALU_pc, 32'h100);
      check_val("addi_vj",  rs_bus.RSALU_Vj, 32'd5);
      check_val("addi_imm", rs_bus.RSALU_imm, 32'd7);
      check_val("addi_rob", {24'd0, rs_bus.RSALU_RoB_index}, 32'd3);
      tick();
      check_val("addi_done", {31'd0, rs_bus.RSALU_en}, 32'd0);

      // stall freezes both an idle and an active issue register
      dispatch(7'd25, 32'h104, 32'd0, 32'h33, 32'h44, ND, ND, 8'd9);
      Sys_rdy = 1'b0;
      tick();
      check_val("stall_hold0", {31'd0, rs_bus.RSALU_en}, 32'd0);
      Sys_rdy = 1'b1;
      tick();
      check_val("stall_en",  {31'd0, rs_bus.RSALU_en}, 32'd1);
      check_val("stall_vk",  rs_bus.RSALU_Vk, 32'h44);
      check_val("stall_rob", {24'd0, rs_bus.RSALU_RoB_index}, 32'd9);
      Sys_rdy = 1'b0;
      tick();
      check_val("stall_hold1", {31'd0, rs_bus.RSALU_en}, 32'd1);
      check_val("stall_hrob",  {24'd0, rs_bus.RSALU_RoB_index}, 32'd9);
      Sys_rdy = 1'b1;
      tick();
      check_val("stall_done", {31'd0, rs_bus.RSALU_en}, 32'd0);

      // add waiting on tag 4, woken by the load bus
      dispatch(7'd1, 32'h108, 32'd0, 32'd0, 32'd2, 9'd4, ND, 8'd5);
      tick();
      check_val("add_wait", {31'd0, rs_bus.RSALU_en}, 32'd0);
      rs_bus.CDBRS_LSB_en = 1'b1; rs_bus.CDBRS_LSB_RoB_index = 8'd4; rs_bus.CDBRS_LSB_value = 32'h10;
      tick();
      rs_bus.CDBRS_LSB_en = 1'b0;
      check_val("add_lat0", {31'd0, rs_bus.RSALU_en}, 32'd0);
      tick();
      check_val("add_en",  {31'd0, rs_bus.RSALU_en}, 32'd1);
      check_val("add_vj",  rs_bus.RSALU_Vj, 32'h10);
      check_val("add_vk",  rs_bus.RSALU_Vk, 32'd2);
      check_val("add_rob", {24'd0, rs_bus.RSALU_RoB_index}, 32'd5);
      tick();

      // dispatch while the producing result is on the RS bus
      rs_bus.CDBRS_RS_en = 1'b1; rs_bus.CDBRS_RS_RoB_index = 8'd6; rs_bus.CDBRS_RS_value = 32'hAA;
      dispatch(7'd2, 32'h10C, 32'd0, 32'd0, 32'd1, 9'd6, ND, 8'd7);
      rs_bus.CDBRS_RS_en = 1'b0;
      tick();
      check_val("fwd_en",  {31'd0, rs_bus.RSALU_en}, 32'd1);
      check_val("fwd_vj",  rs_bus.RSALU_Vj, 32'hAA);
      check_val("fwd_rob", {24'd0, rs_bus.RSALU_RoB_index}, 32'd7);
      tick();

      // both buses carry the tag at dispatch: RS bus value wins
      rs_bus.CDBRS_RS_en  = 1'b1; rs_bus.CDBRS_RS_RoB_index  = 8'd2; rs_bus.CDBRS_RS_value  = 32'h11;
      rs_bus.CDBRS_LSB_en = 1'b1; rs_bus.CDBRS_LSB_RoB_index = 8'd2; rs_bus.CDBRS_LSB_value = 32'h22;
      dispatch(7'd3, 32'h110, 32'd0, 32'h7, 32'd0, ND, 9'd2, 8'd8);
      rs_bus.CDBRS_RS_en = 1'b0; rs_bus.CDBRS_LSB_en = 1'b0;
      tick();
      check_val("tie_en", {31'd0, rs_bus.RSALU_en}, 32'd1);
      check_val("tie_vk", rs_bus.RSALU_Vk, 32'h11);
      tick();

      // both operands resolved in the same cycle from different buses
      dispatch(7'd4, 32'h114, 32'd0, 32'd0, 32'd0, 9'd10, 9'd11, 8'd10);
      rs_bus.CDBRS_RS_en  = 1'b1; rs_bus.CDBRS_RS_RoB_index  = 8'd10; rs_bus.CDBRS_RS_value  = 32'h1234;
      rs_bus.CDBRS_LSB_en = 1'b1; rs_bus.CDBRS_LSB_RoB_index = 8'd11; rs_bus.CDBRS_LSB_value = 32'h5678;
      tick();
      rs_bus.CDBRS_RS_en = 1'b0; rs_bus.CDBRS_LSB_en = 1'b0;
      check_val("dual_lat0", {31'd0, rs_bus.RSALU_en}, 32'd0);
      tick();
      check_val("dual_vj", rs_bus.RSALU_Vj, 32'h1234);
      check_val("dual_vk", rs_bus.RSALU_Vk, 32'h5678);
      tick();

      // fill 15 entries waiting on tag 1
      for (int k = 0; k < 15; k++) begin
         dispatch(7'd20, 32'h200 + 32'(k * 4), 32'd0, 32'd0, 32'(k), 9'd1, ND, 8'(k));
         if (k == 13) check_val("full_at14", {31'd0, rs_bus.RSDP_full}, 32'd0);
      end
      check_val("full_at15", {31'd0, rs_bus.RSDP_full}, 32'd1);
      check_val("fill_noissue", {31'd0, rs_bus.RSALU_en}, 32'd0);
      rs_bus.CDBRS_RS_en = 1'b1; rs_bus.CDBRS_RS_RoB_index = 8'd1; rs_bus.CDBRS_RS_value = 32'h55;
      tick();
      rs_bus.CDBRS_RS_en = 1'b0;
      check_val("drain_lat0", {31'd0, rs_bus.RSALU_en}, 32'd0);
      check_val("drain_full", {31'd0, rs_bus.RSDP_full}, 32'd1);
      for (int i = 0; i < 15; i++) begin
         tick();
         check_val("drain_en",  {31'd0, rs_bus.RSALU_en}, 32'd1);
         check_val("drain_rob", {24'd0, rs_bus.RSALU_RoB_index}, 32'(i));
         check_val("drain_vk",  rs_bus.RSALU_Vk, 32'(i));
         if (i == 0) begin
            check_val("drain_vj",    rs_bus.RSALU_Vj, 32'h55);
            check_val("drain_unfull", {31'd0, rs_bus.RSDP_full}, 32'd0);
         end
         $display("drain slot=%0d rob=%0d", i, rs_bus.RSALU_RoB_index);
      end
      tick();
      check_val("drain_done", {31'd0, rs_bus.RSALU_en}, 32'd0);

      // flush with 8 waiters, an active issue, a CDB match and a stall all at once
      for (int k = 0; k < 8; k++) begin
         dispatch(7'd21, 32'h300, 32'd0, 32'd0, 32'd0, 9'd3, ND, 8'(k));
      end
      dispatch(7'd22, 32'h320, 32'd0, 32'h1, 32'h2, ND, ND, 8'h20);
      tick();
      check_val("pre_flush_en",  {31'd0, rs_bus.RSALU_en}, 32'd1);
      check_val("pre_flush_rob", {24'd0, rs_bus.RSALU_RoB_index}, 32'h20);
      rs_bus.RoBRS_pre_judge = 1'b0;
      rs_bus.CDBRS_RS_en = 1'b1; rs_bus.CDBRS_RS_RoB_index = 8'd3; rs_bus.CDBRS_RS_value = 32'h9;
      Sys_rdy = 1'b0;
      tick();
      rs_bus.RoBRS_pre_judge = 1'b1;
      rs_bus.CDBRS_RS_en = 1'b0;
      Sys_rdy = 1'b1;
      check_val("flush_en",   {31'd0, rs_bus.RSALU_en}, 32'd0);
      check_val("flush_full", {31'd0, rs_bus.RSDP_full}, 32'd0);
      tick();
      check_val("flush_idle1", {31'd0, rs_bus.RSALU_en}, 32'd0);
      rs_bus.CDBRS_RS_en = 1'b1; rs_bus.CDBRS_RS_RoB_index = 8'd3; rs_bus.CDBRS_RS_value = 32'h9;
      tick();
      rs_bus.CDBRS_RS_en = 1'b0;
      tick();
      check_val("flush_ghost", {31'd0, rs_bus.RSALU_en}, 32'd0);

      // asynchronous reset with 3 waiting entries and an active issue
      for (int k = 0; k < 3; k++) begin
         dispatch(7'd23, 32'h400, 32'd0, 32'd0, 32'd0, 9'd5, ND, 8'(k));
      end
      dispatch(7'd24, 32'h410, 32'd0, 32'h99, 32'd0, ND, ND, 8'h31);
      tick();
      check_val("prerst_en", {31'd0, rs_bus.RSALU_en}, 32'd1);
      check_val("prerst_vj", rs_bus.RSALU_Vj, 32'h99);
      #2;
      Sys_rst = 1'b1;
      #1;
      check_val("arst_en",   {31'd0, rs_bus.RSALU_en}, 32'd0);
      check_val("arst_vj",   rs_bus.RSALU_Vj, 32'd0);
      check_val("arst_full", {31'd0, rs_bus.RSDP_full}, 32'd0);
      tick();
      Sys_rst = 1'b0;
      rs_bus.CDBRS_RS_en = 1'b1; rs_bus.CDBRS_RS_RoB_index = 8'd5; rs_bus.CDBRS_RS_value = 32'h7;
      tick();
      rs_bus.CDBRS_RS_en = 1'b0;
      tick();
      check_val("arst_noissue1", {31'd0, rs_bus.RSALU_en}, 32'd0);
      tick();
      check_val("arst_noissue2", {31'd0, rs_bus.RSALU_en}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
